// File: rtl/welford_pkg.sv
// Shared state encoding and default sizing for the popcount window accumulator.
package welford_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 20;
  localparam int DEFAULT_WINDOW      = 64;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/popcount_stage.sv
// Combinational population count of one input bitmap; the parent registers it.
module popcount_stage #(
  parameter int INPUT_WIDTH = 20,
  parameter int POP_WIDTH   = $clog2(INPUT_WIDTH + 1)
) (
  input  logic [INPUT_WIDTH-1:0] i_bitmap,
  output logic [POP_WIDTH-1:0]   o_pop
);

  always_comb begin
    o_pop = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      o_pop = o_pop + POP_WIDTH'(i_bitmap[i]);
    end
  end

endmodule

// File: rtl/popcount_window_accumulator.sv
// Accumulates per-sample popcounts over a window of samples and reports sum,
// sample count and peak popcount through a valid/ready output.
module popcount_window_accumulator
  import welford_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
  parameter int WINDOW       = DEFAULT_WINDOW,
  parameter int POP_WIDTH    = $clog2(INPUT_WIDTH + 1),
  parameter int SAMPLE_WIDTH = $clog2(WINDOW + 1),
  parameter int SUM_WIDTH    = POP_WIDTH + SAMPLE_WIDTH
) (
  input  logic                    axis_aclk,
  input  logic                    axis_resetn,
  input  logic                    in_valid,
  input  logic [INPUT_WIDTH-1:0]  in_bitmap,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_WIDTH-1:0]    out_sum,
  output logic [SAMPLE_WIDTH-1:0] out_samples,
  output logic [POP_WIDTH-1:0]    out_max
);

  logic [POP_WIDTH-1:0]    w_pop;
  logic                    w_handshake;
  logic                    w_close;
  logic                    w_load;
  logic                    w_release;
  state_t                  r_state;
  state_t                  w_nextState;
  logic [SAMPLE_WIDTH-1:0] r_accCnt;
  logic                    r_pValid;
  logic [POP_WIDTH-1:0]    r_pPop;
  logic [SUM_WIDTH-1:0]    r_sum;
  logic [POP_WIDTH-1:0]    r_max;
  logic                    r_drainWait;

  popcount_stage #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .POP_WIDTH   (POP_WIDTH)
  ) u_popcount (
    .i_bitmap (in_bitmap),
    .o_pop    (w_pop)
  );

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // in_ready is gated by reset so it reads 0 while the block is held in reset.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    w_close     = 1'b0;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready    = axis_resetn;
        w_handshake = in_valid & axis_resetn;
        if (w_handshake && (r_accCnt == SAMPLE_WIDTH'(WINDOW - 1))) begin
          w_close = 1'b1;
        end
        if (flush && ((r_accCnt != '0) || w_handshake)) begin
          w_close = 1'b1;
        end
        if (w_close) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drainWait) begin
          w_load      = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_nextState = ACCUM;
        end
      end
      default: w_nextState = ACCUM;
    endcase
  end

  // DRAIN spends one cycle letting the final popcount pass through stage A,
  // then publishes on the next edge, two edges after the window closed.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_accCnt    <= '0;
      r_pValid    <= 1'b0;
      r_pPop      <= '0;
      r_sum       <= '0;
      r_max       <= '0;
      r_drainWait <= 1'b0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_samples <= '0;
      out_max     <= '0;
    end else begin
      r_pValid    <= w_handshake;
      r_drainWait <= (r_state == DRAIN) && !r_drainWait;
      if (w_handshake) begin
        r_accCnt <= r_accCnt + 1'b1;
        r_pPop   <= w_pop;
      end
      if (r_pValid) begin
        r_sum <= r_sum + SUM_WIDTH'(r_pPop);
        if (r_pPop > r_max) begin
          r_max <= r_pPop;
        end
      end
      if (w_load) begin
        out_valid   <= 1'b1;
        out_sum     <= r_sum;
        out_samples <= r_accCnt;
        out_max     <= r_max;
      end
      if (w_release) begin
        out_valid <= 1'b0;
        r_sum     <= '0;
        r_max     <= '0;
        r_accCnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Self-checking bench for popcount_window_accumulator with WINDOW=4, INPUT_WIDTH=20.
module tb_popcount_window_accumulator;

  localparam int IW   = 20;
  localparam int WIN  = 4;
  localparam int PW   = $clog2(IW + 1);
  localparam int SW   = $clog2(WIN + 1);
  localparam int SUMW = PW + SW;

  logic            clk;
  logic            resetn;
  logic            inValid;
  logic [IW-1:0]   inBitmap;
  logic            inReady;
  logic            flushIn;
  logic            outValid;
  logic            outReady;
  logic [SUMW-1:0] outSum;
  logic [SW-1:0]   outSamples;
  logic [PW-1:0]   outMax;

  int checks = 0;
  int errors = 0;
  int modelPops[$];

  popcount_window_accumulator #(
    .INPUT_WIDTH (IW),
    .WINDOW      (WIN)
  ) dut (
    .axis_aclk   (clk),
    .axis_resetn (resetn),
    .in_valid    (inValid),
    .in_bitmap   (inBitmap),
    .in_ready    (inReady),
    .flush       (flushIn),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_sum     (outSum),
    .out_samples (outSamples),
    .out_max     (outMax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the window is just the list of accepted popcounts.
  function automatic int modelSum();
    int s = 0;
    foreach (modelPops[i]) s += modelPops[i];
    return s;
  endfunction

  function automatic int modelMax();
    int m = 0;
    foreach (modelPops[i]) if (modelPops[i] > m) m = modelPops[i];
    return m;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendSample(input logic [IW-1:0] b, input bit withFlush);
    inValid  = 1'b1;
    inBitmap = b;
    flushIn  = withFlush;
    nextCycle();
    inValid  = 1'b0;
    flushIn  = 1'b0;
    inBitmap = IW'($urandom);
    modelPops.push_back($countones(b));
  endtask

  task automatic flushPulse();
    flushIn = 1'b1;
    nextCycle();
    flushIn = 1'b0;
  endtask

  task automatic ackOutput();
    outReady = 1'b1;
    nextCycle();
    outReady = 1'b0;
    modelPops.delete();
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!outValid && cyc < 20) begin
      nextCycle();
      cyc++;
    end
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL valid_timeout: out_valid=%b after %0d cycles, required 1", outValid, cyc);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b0 || outSum !== '0 || outSamples !== '0 || outMax !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b sum=%0d samples=%0d max=%0d, required all 0",
               inReady, outValid, outSum, outSamples, outMax);
    end
    nextCycle();
    resetn = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: in_ready=%b, required 1", inReady);
    end
    nextCycle();
  endtask

  task automatic test_full_window();
    for (int i = 0; i < WIN; i++) sendSample(20'hFFFFF, 1'b0);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_latency1: out_valid=%b in_ready=%b, required 0 0", outValid, inReady);
    end
    nextCycle();
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_latency2: out_valid=%b, required 0", outValid);
    end
    nextCycle();
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_latency3: out_valid=%b, required 1", outValid);
    end
    checks++;
    if (outSum !== SUMW'(modelSum()) || outSamples !== SW'(modelPops.size()) || outMax !== PW'(modelMax())
        || outSum !== SUMW'(80) || outMax !== PW'(20)) begin
      errors++;
      $display("[TB] FAIL full_result: sum=%0d samples=%0d max=%0d, required %0d %0d %0d",
               outSum, outSamples, outMax, modelSum(), modelPops.size(), modelMax());
    end
    ackOutput();
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_release: out_valid=%b in_ready=%b, required 0 1", outValid, inReady);
    end
  endtask

  task automatic test_gaps();
    logic [IW-1:0] pats [4];
    int cyc;
    pats[0] = 20'h00001; pats[1] = 20'h00003; pats[2] = 20'h00007; pats[3] = 20'h0000F;
    for (int i = 0; i < 4; i++) begin
      repeat (i + 1) nextCycle();
      sendSample(pats[i], 1'b0);
    end
    waitValid(cyc);
    checks++;
    if (cyc != 2 || outSum !== SUMW'(10) || outSamples !== SW'(4) || outMax !== PW'(4)) begin
      errors++;
      $display("[TB] FAIL gaps_result: latency=%0d sum=%0d samples=%0d max=%0d, required 2 10 4 4",
               cyc, outSum, outSamples, outMax);
    end
    ackOutput();
  endtask

  task automatic test_flush();
    int cyc;
    sendSample(20'h000FF, 1'b0);
    sendSample(20'h00000, 1'b0);
    nextCycle();
    flushPulse();
    waitValid(cyc);
    checks++;
    if (cyc != 2 || outSum !== SUMW'(8) || outSamples !== SW'(2) || outMax !== PW'(8)) begin
      errors++;
      $display("[TB] FAIL flush_result: latency=%0d sum=%0d samples=%0d max=%0d, required 2 8 2 8",
               cyc, outSum, outSamples, outMax);
    end
    ackOutput();
    sendSample(20'h000FF, 1'b0);
    sendSample(20'h00000, 1'b0);
    sendSample(20'h00003, 1'b1);
    waitValid(cyc);
    checks++;
    if (cyc != 2 || outSum !== SUMW'(10) || outSamples !== SW'(3) || outMax !== PW'(8)) begin
      errors++;
      $display("[TB] FAIL flush_coincident: latency=%0d sum=%0d samples=%0d max=%0d, required 2 10 3 8",
               cyc, outSum, outSamples, outMax);
    end
    ackOutput();
  endtask

  task automatic test_hold_stall();
    int cyc;
    int expSum, expMax;
    for (int i = 0; i < WIN; i++) sendSample(IW'($urandom), 1'b0);
    expSum = modelSum();
    expMax = modelMax();
    waitValid(cyc);
    for (int i = 0; i < 10; i++) begin
      inValid  = 1'($urandom);
      inBitmap = IW'($urandom);
      #1;
      checks++;
      if (outValid !== 1'b1 || inReady !== 1'b0 || outSum !== SUMW'(expSum) || outSamples !== SW'(WIN)
          || outMax !== PW'(expMax)) begin
        errors++;
        $display("[TB] FAIL hold_stable[%0d]: valid=%b ready=%b sum=%0d samples=%0d max=%0d, required 1 0 %0d %0d %0d",
                 i, outValid, inReady, outSum, outSamples, outMax, expSum, WIN, expMax);
      end
      nextCycle();
    end
    inValid = 1'b0;
    ackOutput();
    for (int i = 0; i < WIN; i++) sendSample(20'h00001, 1'b0);
    waitValid(cyc);
    checks++;
    if (outSum !== SUMW'(4) || outSamples !== SW'(4) || outMax !== PW'(1)) begin
      errors++;
      $display("[TB] FAIL hold_next_window: sum=%0d samples=%0d max=%0d, required 4 4 1",
               outSum, outSamples, outMax);
    end
    ackOutput();
  endtask

  task automatic test_reset_midwindow();
    int cyc;
    sendSample(20'hFFFFF, 1'b0);
    sendSample(20'h0F0F0, 1'b0);
    resetn = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b0 || outSum !== '0 || outSamples !== '0 || outMax !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_state: in_ready=%b out_valid=%b sum=%0d samples=%0d max=%0d, required all 0",
               inReady, outValid, outSum, outSamples, outMax);
    end
    nextCycle();
    resetn = 1'b1;
    modelPops.delete();
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL midreset_idle[%0d]: out_valid=%b in_ready=%b, required 0 1", i, outValid, inReady);
      end
    end
    for (int i = 0; i < WIN; i++) sendSample(20'h00001, 1'b0);
    waitValid(cyc);
    checks++;
    if (outSum !== SUMW'(4) || outSamples !== SW'(4) || outMax !== PW'(1)) begin
      errors++;
      $display("[TB] FAIL midreset_window: sum=%0d samples=%0d max=%0d, required 4 4 1",
               outSum, outSamples, outMax);
    end
    ackOutput();
  endtask

  task automatic test_empty_flush();
    flushPulse();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL empty_flush[%0d]: out_valid=%b in_ready=%b, required 0 1", i, outValid, inReady);
      end
      nextCycle();
    end
  endtask

  task automatic test_random();
    int cyc;
    int n;
    logic [IW-1:0] b;
    for (int w = 0; w < 12; w++) begin
      n = $urandom_range(1, WIN);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) nextCycle();
        b = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : IW'($urandom);
        sendSample(b, (n < WIN) && (i == n - 1) && ($urandom_range(0, 1) == 1));
      end
      if (n < WIN && outValid === 1'b0 && inReady === 1'b1) begin
        repeat ($urandom_range(0, 2)) nextCycle();
        flushPulse();
      end
      waitValid(cyc);
      checks++;
      if (outSum !== SUMW'(modelSum()) || outSamples !== SW'(modelPops.size()) || outMax !== PW'(modelMax())) begin
        errors++;
        $display("[TB] FAIL random_window[%0d]: sum=%0d samples=%0d max=%0d, required %0d %0d %0d",
                 w, outSum, outSamples, outMax, modelSum(), modelPops.size(), modelMax());
      end
      repeat ($urandom_range(0, 3)) nextCycle();
      ackOutput();
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random_release[%0d]: out_valid=%b in_ready=%b, required 0 1", w, outValid, inReady);
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    inValid  = 1'b0;
    inBitmap = '0;
    flushIn  = 1'b0;
    outReady = 1'b0;
    test_reset();
    test_full_window();
    test_gaps();
    test_flush();
    test_hold_stall();
    test_reset_midwindow();
    test_empty_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_window_accumulator.md
POPCOUNT_WINDOW_ACCUMULATOR -- requirements
Module: popcount_window_accumulator

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 20, width of each input bitmap sample.
REQ-002 SHALL have parameter WINDOW, default 64, number of samples per window (WINDOW >= 2).
REQ-003 SHALL have parameter POP_WIDTH, default $clog2(INPUT_WIDTH+1), width of one sample's popcount.
REQ-004 SHALL have parameter SAMPLE_WIDTH, default $clog2(WINDOW+1), and SUM_WIDTH, default POP_WIDTH+SAMPLE_WIDTH.
REQ-005 SHALL have one clock and an asynchronous active-low reset: axis_aclk input 1 (clock); axis_resetn input 1 (reset, active-low, asynchronous).
REQ-006 SHALL have ports: in_valid input 1 (sample offered); in_bitmap input INPUT_WIDTH (sample); in_ready output 1 (sample accepted when both high).
REQ-007 SHALL have ports: flush input 1 (single-cycle pulse, close current window early).
REQ-008 SHALL have ports: out_valid output 1; out_ready input 1; out_sum output SUM_WIDTH (sum of popcounts); out_samples output SAMPLE_WIDTH (samples in window); out_max output POP_WIDTH (largest single-sample popcount).

Function
REQ-009 SHALL implement a 2-stage pipeline: stage P registers popcount(in_bitmap) on handshake; stage A adds the registered popcount to the running sum and updates the running max.
REQ-010 SHALL keep a handshake counter acc_cnt (samples accepted in current window) separate from pipeline contents.
REQ-011 SHALL use FSM states ACCUM, DRAIN, HOLD; reset state ACCUM.
REQ-012 ACCUM: in_ready = 1; handshake increments acc_cnt; if acc_cnt reaches WINDOW on this handshake -> DRAIN.
REQ-013 ACCUM with flush=1 and (acc_cnt>0 or handshake this cycle) -> DRAIN; a handshake in the same cycle SHALL be included in the window.
REQ-014 flush with acc_cnt=0 and no handshake SHALL be ignored; flush in DRAIN or HOLD SHALL be ignored.
REQ-015 DRAIN: in_ready = 0; after the last sample has left stage A, load out_sum/out_samples/out_max, set out_valid, -> HOLD.
REQ-016 Latency: out_valid SHALL rise exactly 2 cycles after the clock edge of the window-closing handshake (or of the flush edge if no handshake then).
REQ-017 HOLD: in_ready = 0; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-018 HOLD with out_ready=1: clear out_valid, sum, max, acc_cnt -> ACCUM; in_ready = 1 the next cycle.
REQ-019 Sum SHALL never overflow: SUM_WIDTH covers WINDOW*INPUT_WIDTH; popcount SHALL be exact for an all-ones input.
REQ-020 in_bitmap SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-021 While axis_resetn=0, all state SHALL clear asynchronously: state=ACCUM, acc_cnt, pipeline valid, sum, max = 0.
REQ-022 Reset values: in_ready=0 during reset, 1 after deassertion; out_valid=0; out_sum=0; out_samples=0; out_max=0.
REQ-023 Reset mid-window or in HOLD SHALL discard partial results; no out_valid is produced for the interrupted window.

Structure
REQ-024 FSM state encoding and default parameter constants SHALL live in shared package welford_pkg.
REQ-025 Popcount SHALL be a sub-module popcount_stage (combinational, parameter INPUT_WIDTH, output POP_WIDTH), registered by the parent.
REQ-026 Implementation SHALL be synthesizable Verilog, no latches, single clock domain.

Verification (INPUT_WIDTH=20, WINDOW=4)
REQ-027 4 back-to-back samples 0xFFFFF -> out_sum=80, out_samples=4, out_max=20, out_valid 2 cycles after 4th handshake.
REQ-028 Samples 0x00001, 0x00003, 0x00007, 0x0000F with gaps -> out_sum=10, out_samples=4, out_max=4.
REQ-029 Samples 0x000FF, 0x00000 then flush -> out_sum=8, out_samples=2, out_max=8; flush coincident with 3rd sample 0x00003 -> out_sum=10, out_samples=3.
REQ-030 out_ready held 0 for 10 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> next window starts from sum 0.
REQ-031 axis_resetn pulsed low after 2 samples -> all outputs 0; next 4 samples of 0x00001 -> out_sum=4.
REQ-032 flush with no samples accepted -> no out_valid, in_ready stays 1.
